// File: rtl/hub75_fetchshift_if.sv
// hub75_fetchshift_if: start/busy handshake, framebuffer read port and panel pins of the column engine
interface hub75_fetchshift_if #(
    parameter int ROW_W = 6,
    parameter int BIT_W = 3,
    parameter int COLS  = 64
);
    localparam int COL_W = $clog2(COLS);
    logic                   fetchshift_start;
    logic [ROW_W-1:0]       row_in;
    logic [BIT_W-1:0]       bit_in;
    logic                   fetchshift_busy;
    logic                   fb_rd_en;
    logic [ROW_W+COL_W-1:0] fb_addr;
    logic [47:0]            fb_rd_data;
    logic                   r0, g0, b0, r1, g1, b1;
    logic                   pix_clk;
    modport master (
        output fetchshift_start, row_in, bit_in, fb_rd_data,
        input  fetchshift_busy, fb_rd_en, fb_addr, r0, g0, b0, r1, g1, b1, pix_clk
    );
    modport slave (
        input  fetchshift_start, row_in, bit_in, fb_rd_data,
        output fetchshift_busy, fb_rd_en, fb_addr, r0, g0, b0, r1, g1, b1, pix_clk
    );
endinterface

// File: rtl/hub75_fetchshift.sv
// hub75_fetchshift: fetches one row of framebuffer words and shifts a single bit-plane to the HUB75 RGB pins
module hub75_fetchshift #(
    parameter int COLS  = 64,
    parameter int ROW_W = 6,
    parameter int BIT_W = 3,
    parameter int HALF  = 2
) (
    input logic               sys_clk,
    input logic               rst_n,
    hub75_fetchshift_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, HIGH, DONE} state_t;
    state_t             state;
    logic [ROW_W-1:0]   row_l;
    logic [2:0]         plane;
    logic [2:0]         plane_in;
    logic [COL_W-1:0]   col;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         rgb;
    logic [5:0]         px;
    logic               busy;
    logic               rd_en;
    logic               pix;
    logic [ROW_W+COL_W-1:0] addr;
    // bit 0 is the heaviest weight in the main FSM's table, so it maps to the MSB plane
    always_comb plane_in = (bus.bit_in == '0) ? 3'd7 : 3'(bus.bit_in - BIT_W'(1));
    always_comb begin
        px = '0;
        for (int i = 0; i < 6; i++) px[i] = bus.fb_rd_data[i*8 + int'(plane)];
    end
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= IDLE;
            row_l <= '0;
            plane <= '0;
            col   <= '0;
            cnt   <= '0;
            rgb   <= '0;
            busy  <= 1'b0;
            rd_en <= 1'b0;
            pix   <= 1'b0;
            addr  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.fetchshift_start) begin
                    row_l <= bus.row_in;
                    plane <= plane_in;
                    col   <= '0;
                    busy  <= 1'b1;
                    rd_en <= 1'b1;
                    addr  <= {bus.row_in, COL_W'(0)};
                    state <= ADDR;
                end
                ADDR: begin
                    rd_en <= 1'b0;
                    cnt   <= '0;
                    state <= DATA;
                end
                // read data arrives during the first DATA cycle
                DATA: begin
                    if (cnt == '0) rgb <= px;
                    if (cnt == CNT_W'(HALF - 1)) begin
                        pix   <= 1'b1;
                        cnt   <= '0;
                        state <= HIGH;
                    end else cnt <= cnt + CNT_W'(1);
                end
                HIGH: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        pix <= 1'b0;
                        cnt <= '0;
                        if (col == COL_W'(COLS - 1)) state <= DONE;
                        else begin
                            col   <= col + COL_W'(1);
                            rd_en <= 1'b1;
                            addr  <= {row_l, col + COL_W'(1)};
                            state <= ADDR;
                        end
                    end else cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.fetchshift_busy = busy;
    assign bus.fb_rd_en        = rd_en;
    assign bus.fb_addr         = addr;
    assign bus.pix_clk         = pix;
    assign {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} = rgb;
endmodule

// File: tb/tb_hub75_fetchshift.sv
// tb_hub75_fetchshift: directed transfers checked against a cycle-count model of the column engine
module tb_hub75_fetchshift;
    localparam int COLS  = 64;
    localparam int ROW_W = 6;
    localparam int BIT_W = 3;
    localparam int HALF  = 2;
    localparam int P     = 1 + 2*HALF;
    localparam int LEN   = COLS*P;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;
    hub75_fetchshift_if #(.ROW_W(ROW_W), .BIT_W(BIT_W), .COLS(COLS)) bus();
    hub75_fetchshift #(.COLS(COLS), .ROW_W(ROW_W), .BIT_W(BIT_W), .HALF(HALF)) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int mode = 0;
    logic chk_en = 1'b0;
    logic [5:0] rgb;
    assign rgb = {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1};
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask
    // mode 0: constant word Rt=0x80 Gb=0x01; mode 1: Rt=col with other channels derived from row/col
    function automatic logic [47:0] word(input logic [11:0] a);
        logic [7:0] c, r;
        c = {2'b00, a[5:0]};
        r = {2'b00, a[11:6]};
        if (mode == 0) return 48'h80_00_00_00_01_00;
        return {c, ~c, r, c ^ 8'h5A, 8'hA5, c ^ r};
    endfunction
    function automatic logic [5:0] pix(input logic [11:0] a, input logic [BIT_W-1:0] b);
        int p;
        logic [47:0] w;
        p = (b == 0) ? 7 : int'(b) - 1;
        w = word(a);
        return {w[40+p], w[32+p], w[24+p], w[16+p], w[8+p], w[p]};
    endfunction
    always @(posedge sys_clk) if (bus.fb_rd_en) bus.fb_rd_data <= word(bus.fb_addr);
    // model: outputs are a function of the number of cycles since the accepted start
    logic             m_act = 1'b0;
    int               m_k = 0;
    logic [ROW_W-1:0] m_row = '0;
    logic [BIT_W-1:0] m_bit = '0;
    logic [5:0]       m_last = '0;
    logic             m_rst = 1'b1;
    always @(posedge sys_clk) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_k <= 0;
            m_last <= '0;
            m_rst <= 1'b1;
        end else if (!m_act && bus.fetchshift_start) begin
            m_act <= 1'b1;
            m_k <= 1;
            m_row <= bus.row_in;
            m_bit <= bus.bit_in;
            m_rst <= 1'b0;
        end else if (m_act) begin
            m_k <= m_k + 1;
            if (m_k == LEN) m_last <= pix({m_row, 6'(COLS-1)}, m_bit);
            if (m_k == LEN + 1) begin
                m_act <= 1'b0;
                m_k <= 0;
            end
        end
    end
    always @(negedge sys_clk) if (chk_en) begin
        int ph, c;
        logic e_pix, e_en, rgb_chk;
        logic [5:0] e_rgb;
        logic [11:0] e_addr;
        e_pix = 1'b0;
        e_en = 1'b0;
        e_rgb = m_last;
        rgb_chk = 1'b1;
        chk("busy", bus.fetchshift_busy, m_act);
        if (m_act && m_k <= LEN) begin
            ph = (m_k - 1) % P;
            c = (m_k - 1) / P;
            e_addr = {m_row, 6'(c)};
            e_pix = ph > HALF;
            e_en = ph == 0;
            if (ph > HALF) e_rgb = pix(e_addr, m_bit);
            else if (ph == 0 && c > 0) e_rgb = pix({m_row, 6'(c - 1)}, m_bit);
            else if (ph != 0) rgb_chk = 1'b0;
            if (ph == 0) chk("fb_addr", bus.fb_addr, e_addr);
        end
        if (!m_act && m_rst) chk("fb_addr_rst", bus.fb_addr, 0);
        chk("pix_clk", bus.pix_clk, e_pix);
        chk("fb_rd_en", bus.fb_rd_en, e_en);
        if (rgb_chk) chk("rgb", rgb, e_rgb);
    end
    // event logs for the literal expectations
    logic pix_q = 1'b0;
    int n_edge = 0, n_rd = 0, n_busy = 0;
    logic [5:0]  samp [4096];
    logic [11:0] alog [4096];
    always @(negedge sys_clk) begin
        if (bus.pix_clk && !pix_q) begin
            samp[n_edge] = rgb;
            n_edge++;
        end
        pix_q = bus.pix_clk;
        if (bus.fb_rd_en) begin
            alog[n_rd] = bus.fb_addr;
            n_rd++;
        end
        if (bus.fetchshift_busy) n_busy++;
    end
    task automatic pulse(input logic [ROW_W-1:0] r, input logic [BIT_W-1:0] b);
        bus.fetchshift_start = 1'b1;
        bus.row_in = r;
        bus.bit_in = b;
        @(posedge sys_clk);
        #1 bus.fetchshift_start = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (!bus.fetchshift_busy) return;
        end
        chk("busy_timeout", 1, 0);
    endtask
    task automatic transfer(input logic [ROW_W-1:0] r, input logic [BIT_W-1:0] b,
                            output int e0, output int a0, output int b0);
        e0 = n_edge;
        a0 = n_rd;
        b0 = n_busy;
        pulse(r, b);
        @(negedge sys_clk);
        chk("busy_rise", bus.fetchshift_busy, 1);
        wait_idle();
    endtask
    initial begin
        int e0, a0, b0, mis;
        logic [3:0] seq;
        bus.fetchshift_start = 1'b0;
        bus.row_in = '0;
        bus.bit_in = '0;
        @(posedge sys_clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_busy", bus.fetchshift_busy, 0);
        chk("rst_pins", {rgb, bus.pix_clk, bus.fb_rd_en}, 0);
        #1 rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        // row 5, bit 1 on the constant word: only g1 set
        transfer(6'd5, 3'd1, e0, a0, b0);
        chk("edges_r5", n_edge - e0, 64);
        chk("reads_r5", n_rd - a0, 64);
        chk("busy_len_r5", n_busy - b0, 321);
        chk("addr_first", alog[a0], 12'h140);
        chk("addr_last", alog[a0 + 63], 12'h17F);
        mis = 0;
        for (int i = 0; i < 64; i++) if (samp[e0 + i] !== 6'b000010) mis++;
        chk("g1_only", mis, 0);
        @(posedge sys_clk);
        #1;
        transfer(6'd7, 3'd0, e0, a0, b0);
        mis = 0;
        for (int i = 0; i < 64; i++) if (samp[e0 + i] !== 6'b100000) mis++;
        chk("r0_only", mis, 0);
        // column-indexed data, plane 1
        mode = 1;
        @(posedge sys_clk);
        #1;
        transfer(6'd2, 3'd2, e0, a0, b0);
        for (int i = 0; i < 4; i++) seq[3-i] = samp[e0 + i][5];
        chk("r0_seq", seq, 4'b0011);
        mis = 0;
        for (int i = 0; i < 64; i++) if (samp[e0 + i][5] !== 1'((i >> 1) & 1)) mis++;
        chk("r0_plane1", mis, 0);
        // a second pulse 40 cycles in is ignored
        @(posedge sys_clk);
        #1;
        e0 = n_edge;
        a0 = n_rd;
        b0 = n_busy;
        pulse(6'd9, 3'd3);
        repeat (39) @(posedge sys_clk);
        #1 pulse(6'd2, 3'd5);
        wait_idle();
        chk("edges_dup", n_edge - e0, 64);
        chk("busy_len_dup", n_busy - b0, 321);
        chk("addr_dup_first", alog[a0], 12'h240);
        chk("addr_dup_last", alog[a0 + 63], 12'h27F);
        // reset while column 20 is high
        @(posedge sys_clk);
        #1 pulse(6'd3, 3'd4);
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (bus.pix_clk && bus.fb_addr[5:0] == 6'd20) break;
        end
        chk("mid_pix_high", bus.pix_clk, 1);
        rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("abort_busy", bus.fetchshift_busy, 0);
        chk("abort_pins", {rgb, bus.pix_clk, bus.fb_rd_en}, 0);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        transfer(6'd11, 3'd6, e0, a0, b0);
        chk("edges_after_rst", n_edge - e0, 64);
        chk("busy_len_after_rst", n_busy - b0, 321);
        // back-to-back: second start in the first idle cycle
        @(posedge sys_clk);
        #1;
        transfer(6'd1, 3'd7, e0, a0, b0);
        pulse(6'd4, 3'd1);
        @(negedge sys_clk);
        chk("b2b_busy", bus.fetchshift_busy, 1);
        wait_idle();
        chk("edges_b2b", n_edge - e0, 128);
        chk("busy_len_b2b", n_busy - b0, 642);
        chk("addr_b2b", alog[a0 + 64], 12'h100);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
